// File: rtl/canvas_stroke_writer.sv
// Writer port of the handwriting canvas RAM: stamps a square brush at the mouse
// cursor (ink or erase) and sweeps the whole canvas to blank on request.
module canvas_stroke_writer #(
  parameter int CANVAS_X0 = 200,
  parameter int CANVAS_Y0 = 100,
  parameter int CANVAS_W  = 280,
  parameter int CANVAS_H  = 280,
  parameter int BRUSH     = 2,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        MOUSE_X,
  input  logic [9:0]        MOUSE_Y,
  input  logic              MOUSE_LEFT,
  input  logic              MOUSE_RIGHT,
  input  logic              clear_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_din,
  output logic              busy,
  output logic              clear_done
);

  localparam int SW = ADDR_W + 3;
  localparam logic [10:0] X0_U = 11'(CANVAS_X0);
  localparam logic [10:0] X1_U = 11'(CANVAS_X0 + CANVAS_W);
  localparam logic [10:0] Y0_U = 11'(CANVAS_Y0);
  localparam logic [10:0] Y1_U = 11'(CANVAS_Y0 + CANVAS_H);
  localparam logic signed [10:0] B_S  = 11'(BRUSH);
  localparam logic signed [10:0] NB_S = 11'sd0 - B_S;
  localparam logic signed [10:0] W_S  = 11'(CANVAS_W);
  localparam logic signed [10:0] H_S  = 11'(CANVAS_H);
  localparam logic signed [SW-1:0] W_ROW = SW'(CANVAS_W);
  localparam logic [SW-1:0] CW = SW'(CANVAS_W);
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(CANVAS_W * CANVAS_H - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PAINT = 2'd1, CLEAR = 2'd2} state_t;

  // Constant-coefficient shift-add; only the brush's first row base needs it,
  // later rows step by CANVAS_W.
  function automatic logic signed [SW-1:0] times_w(input logic signed [10:0] v);
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] ext;
    acc = '0;
    ext = {{(SW-11){v[10]}}, v};
    for (int i = 0; i < SW; i++) begin
      if (CW[i]) acc = acc + (ext <<< i);
      else       acc = acc;
    end
    return acc;
  endfunction

  state_t               state_r;
  logic                 mem_we_r, mem_din_r, busy_r, clear_done_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic signed [10:0]   cx_r, cy_r, dx_r, dy_r;
  logic signed [SW-1:0] row_base_r;
  logic                 ink_r;
  logic [9:0]           last_x_r, last_y_r;
  logic                 last_valid_r;

  logic [10:0]          mx_s, my_s;
  logic                 inside_s, paint_go_s, last_off_s, tvalid_s;
  logic signed [10:0]   scx_s, scy_s, ndx_s, ndy_s, tcol_s, trow_s;
  logic signed [SW-1:0] nrow_s, tbase_s, taddr_s;

  // Cursor qualification and start of a new brush stamp.
  always_comb begin
    mx_s = {1'b0, MOUSE_X};
    my_s = {1'b0, MOUSE_Y};
    inside_s = (mx_s >= X0_U) && (mx_s < X1_U) && (my_s >= Y0_U) && (my_s < Y1_U);
    scx_s = $signed(mx_s - X0_U);
    scy_s = $signed(my_s - Y0_U);
    paint_go_s = inside_s && (MOUSE_LEFT ^ MOUSE_RIGHT) &&
                 (!last_valid_r || (MOUSE_X != last_x_r) || (MOUSE_Y != last_y_r));
  end

  // Next brush offset and its clipped canvas target.
  always_comb begin
    last_off_s = (dx_r == B_S) && (dy_r == B_S);
    if (dx_r == B_S) begin
      ndx_s  = NB_S;
      ndy_s  = dy_r + 11'sd1;
      nrow_s = row_base_r + W_ROW;
    end else begin
      ndx_s  = dx_r + 11'sd1;
      ndy_s  = dy_r;
      nrow_s = row_base_r;
    end
    if (state_r == IDLE) begin
      tcol_s  = scx_s + NB_S;
      trow_s  = scy_s + NB_S;
      tbase_s = times_w(scy_s + NB_S);
    end else begin
      tcol_s  = cx_r + ndx_s;
      trow_s  = cy_r + ndy_s;
      tbase_s = nrow_s;
    end
    tvalid_s = (tcol_s >= 11'sd0) && (tcol_s < W_S) && (trow_s >= 11'sd0) && (trow_s < H_S);
    taddr_s  = tbase_s + {{(SW-11){tcol_s[10]}}, tcol_s};
  end

  // Stroke/clear FSM with registered RAM-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_din_r    <= 1'b0;
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
      cx_r         <= 11'sd0;
      cy_r         <= 11'sd0;
      dx_r         <= 11'sd0;
      dy_r         <= 11'sd0;
      row_base_r   <= '0;
      ink_r        <= 1'b0;
      last_x_r     <= 10'd0;
      last_y_r     <= 10'd0;
      last_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          clear_done_r <= 1'b0;
          mem_we_r     <= 1'b0;
          if (clear_req) begin
            state_r    <= CLEAR;
            busy_r     <= 1'b1;
            mem_we_r   <= 1'b1;
            mem_addr_r <= '0;
            mem_din_r  <= 1'b0;
          end else if (paint_go_s) begin
            // Offset 0 goes out on the same edge that leaves IDLE.
            state_r      <= PAINT;
            busy_r       <= 1'b1;
            cx_r         <= scx_s;
            cy_r         <= scy_s;
            ink_r        <= MOUSE_LEFT;
            last_x_r     <= MOUSE_X;
            last_y_r     <= MOUSE_Y;
            last_valid_r <= 1'b1;
            dx_r         <= NB_S;
            dy_r         <= NB_S;
            row_base_r   <= tbase_s;
            mem_we_r     <= tvalid_s;
            mem_din_r    <= MOUSE_LEFT;
            if (tvalid_s) mem_addr_r <= ADDR_W'(taddr_s);
          end else if (!MOUSE_LEFT && !MOUSE_RIGHT) begin
            last_valid_r <= 1'b0;
          end
        end
        PAINT: begin
          if (clear_req) begin
            state_r    <= CLEAR;
            mem_we_r   <= 1'b1;
            mem_addr_r <= '0;
            mem_din_r  <= 1'b0;
          end else if (last_off_s) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            mem_we_r <= 1'b0;
          end else begin
            dx_r       <= ndx_s;
            dy_r       <= ndy_s;
            row_base_r <= nrow_s;
            mem_we_r   <= tvalid_s;
            mem_din_r  <= ink_r;
            if (tvalid_s) mem_addr_r <= ADDR_W'(taddr_s);
          end
        end
        CLEAR: begin
          if (mem_addr_r == CLEAR_LAST) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            clear_done_r <= 1'b1;
            last_valid_r <= 1'b0;
          end else begin
            mem_addr_r <= mem_addr_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          mem_we_r     <= 1'b0;
          clear_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = mem_din_r;
  assign busy       = busy_r;
  assign clear_done = clear_done_r;

endmodule

// File: tb/tb_canvas_stroke_writer.sv
// Directed, table-driven bench for canvas_stroke_writer: brush stamps, clipping,
// hold-still suppression, clear sweep, abort and asynchronous reset.
module tb_canvas_stroke_writer;

  logic        clk, rst;
  logic [9:0]  MOUSE_X, MOUSE_Y;
  logic        MOUSE_LEFT, MOUSE_RIGHT, clear_req;
  logic        mem_we, mem_din, busy, clear_done;
  logic [16:0] mem_addr;

  canvas_stroke_writer dut (
    .clk(clk), .rst(rst), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y),
    .MOUSE_LEFT(MOUSE_LEFT), .MOUSE_RIGHT(MOUSE_RIGHT), .clear_req(clear_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       l;
    logic       r;
    int         writes;
    int         first;
    int         last;
    int         sum;
    logic       din;
    int         busy_cyc;
  } vec_t;

  vec_t vecs[10];
  int n_checks = 0;
  int n_fail = 0;
  int w_cnt, w_first, w_last, w_sum, ones_cnt, busy_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present buttons at (x,y) for 'hold' cycles, then release and observe.
  task automatic stroke(input logic [9:0] x, input logic [9:0] y,
                        input logic l, input logic r, input int hold);
    w_cnt = 0; w_first = -1; w_last = -1; w_sum = 0; ones_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    MOUSE_X = x; MOUSE_Y = y; MOUSE_LEFT = l; MOUSE_RIGHT = r;
    for (int c = 0; c < hold + 40; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_we) begin
        if (w_cnt == 0) w_first = int'(mem_addr);
        w_last = int'(mem_addr);
        w_sum += int'(mem_addr);
        if (mem_din) ones_cnt++;
        w_cnt++;
      end
      if (c == hold - 1) begin
        MOUSE_LEFT = 1'b0;
        MOUSE_RIGHT = 1'b0;
      end
    end
  endtask

  initial begin
    int exp_a, addr_err, din_err, gap_err, done_seen, done_we, done_busy, cyc;

    // x, y, left, right, writes, first, last, addr sum, din, busy cycles
    vecs[0] = '{10'd200, 10'd100, 1'b1, 1'b0,  9,     0,   562,   2529, 1'b1, 25};
    vecs[1] = '{10'd300, 10'd200, 1'b1, 1'b0, 25, 27538, 28662, 702500, 1'b1, 25};
    vecs[2] = '{10'd300, 10'd200, 1'b0, 1'b1, 25, 27538, 28662, 702500, 1'b0, 25};
    vecs[3] = '{10'd300, 10'd200, 1'b1, 1'b1,  0,     0,     0,      0, 1'b1,  0};
    vecs[4] = '{10'd199, 10'd200, 1'b1, 1'b0,  0,     0,     0,      0, 1'b1,  0};
    vecs[5] = '{10'd480, 10'd200, 1'b1, 1'b0,  0,     0,     0,      0, 1'b1,  0};
    vecs[6] = '{10'd479, 10'd379, 1'b1, 1'b0,  9, 77837, 78399, 703062, 1'b1, 25};
    vecs[7] = '{10'd300, 10'd380, 1'b1, 1'b0,  0,     0,     0,      0, 1'b1,  0};
    vecs[8] = '{10'd200, 10'd379, 1'b1, 1'b0,  9, 77560, 78122, 700569, 1'b1, 25};
    vecs[9] = '{10'd479, 10'd100, 1'b0, 1'b1,  9,   277,   839,   5022, 1'b0, 25};

    rst = 1'b1; MOUSE_X = 10'd0; MOUSE_Y = 10'd0;
    MOUSE_LEFT = 1'b0; MOUSE_RIGHT = 1'b0; clear_req = 1'b0;
    #3;
    check("reset mem_we", int'(mem_we), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_din", int'(mem_din), 0);
    check("reset busy", int'(busy), 0);
    check("reset clear_done", int'(clear_done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      stroke(vecs[i].x, vecs[i].y, vecs[i].l, vecs[i].r, 1);
      check($sformatf("v%0d writes", i), w_cnt, vecs[i].writes);
      check($sformatf("v%0d busy cycles", i), busy_cnt, vecs[i].busy_cyc);
      check($sformatf("v%0d addr sum", i), w_sum, vecs[i].sum);
      check($sformatf("v%0d ink writes", i), ones_cnt, vecs[i].din ? vecs[i].writes : 0);
      if (vecs[i].writes > 0) begin
        check($sformatf("v%0d first addr", i), w_first, vecs[i].first);
        check($sformatf("v%0d last addr", i), w_last, vecs[i].last);
      end
    end

    // Holding still must stamp exactly once.
    stroke(10'd300, 10'd200, 1'b1, 1'b0, 100);
    check("hold writes", w_cnt, 25);
    check("hold busy cycles", busy_cnt, 25);
    check("hold addr sum", w_sum, 702500);

    // Clear request on PAINT cycle 10, then reset in the middle of the clear.
    @(negedge clk);
    MOUSE_X = 10'd300; MOUSE_Y = 10'd200; MOUSE_LEFT = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      MOUSE_LEFT = 1'b0;
      if (c == 10) begin
        check("abort write10 we", int'(mem_we), 1);
        check("abort write10 addr", int'(mem_addr), 28098);
        check("abort write10 din", int'(mem_din), 1);
        clear_req = 1'b1;
      end
    end
    @(negedge clk);
    clear_req = 1'b0;
    check("abort clear we", int'(mem_we), 1);
    check("abort clear addr", int'(mem_addr), 0);
    check("abort clear din", int'(mem_din), 0);
    check("abort clear busy", int'(busy), 1);
    repeat (50) @(negedge clk);
    check("clear addr after 50", int'(mem_addr), 50);
    #2 rst = 1'b1;
    #1;
    check("async rst mem_we", int'(mem_we), 0);
    check("async rst mem_addr", int'(mem_addr), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst clear_done", int'(clear_done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post rst busy", int'(busy), 0);
    check("post rst mem_we", int'(mem_we), 0);

    // Full clear sweep with an ignored clear_req in the middle.
    exp_a = 0; addr_err = 0; din_err = 0; gap_err = 0;
    done_seen = 0; done_we = 0; done_busy = 0; cyc = 0;
    @(negedge clk);
    clear_req = 1'b1;
    while (done_seen == 0 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (clear_done) begin
        done_seen = 1;
        done_we = int'(mem_we);
        done_busy = int'(busy);
      end else if (mem_we) begin
        if (int'(mem_addr) != exp_a) addr_err++;
        if (mem_din) din_err++;
        exp_a++;
      end else begin
        gap_err++;
      end
      clear_req = (cyc == 1000) ? 1'b1 : 1'b0;
    end
    clear_req = 1'b0;
    check("clear done seen", done_seen, 1);
    check("clear write count", exp_a, 78400);
    check("clear addr order", addr_err, 0);
    check("clear din zero", din_err, 0);
    check("clear no gaps", gap_err, 0);
    check("clear_done mem_we", done_we, 0);
    check("clear_done busy", done_busy, 0);
    @(negedge clk);
    check("clear_done width", int'(clear_done), 0);
    check("after clear busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
